// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle control FSM and the datapath/memory.
// master = controller (drives controls, sees IR fields/flags); slave = datapath side.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       illegal_instr;
    logic       retire;

    modport master (
        input  op, funct3, Zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr, retire
    );

    modport slave (
        output op, funct3, Zero, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr, retire
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over a shared ALU and one memory port. Only the state is registered.
module multicycle_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JLINK, LUI, AUIPC, TRAP
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   w_next = FETCH;
            FETCH:  if (bus.mem_ready) w_next = DECODE;
            DECODE: begin
                unique case (bus.op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_R:              w_next = EXECR;
                    OP_IMM:            w_next = EXECI;
                    OP_BRANCH:         w_next = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001)
                                                ? BRANCH : TRAP;
                    OP_JAL:            w_next = JAL;
                    OP_JALR:           w_next = JALR;
                    OP_LUI:            w_next = LUI;
                    OP_AUIPC:          w_next = AUIPC;
                    default:           w_next = TRAP;
                endcase
            end
            MEMADR: w_next = (bus.op == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) w_next = MEMWB;
            MEMWR:  if (bus.mem_ready) w_next = FETCH;
            EXECR, EXECI, JAL, JLINK, LUI, AUIPC: w_next = ALUWB;
            JALR:   w_next = JLINK;
            MEMWB, ALUWB, BRANCH, TRAP: w_next = FETCH;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = 2'b00;
        bus.ALUSrcA       = 2'b00;
        bus.ALUSrcB       = 2'b00;
        bus.ALUOp         = 2'b00;
        bus.illegal_instr = 1'b0;
        bus.retire        = 1'b0;
        unique case (r_state)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR, EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = (r_state == EXECI) ? 2'b10 : 2'b00;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                bus.retire    = 1'b1;
            end
            MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.retire   = bus.mem_ready;
            end
            EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.retire  = 1'b1;
                bus.PCWrite = (bus.funct3 == 3'b000 &&  bus.Zero) ||
                              (bus.funct3 == 3'b001 && !bus.Zero);
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            JALR: begin
                bus.ALUSrcA   = 2'b10;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            JLINK: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
            end
            LUI: begin
                bus.ALUSrcA = 2'b11;
                bus.ALUSrcB = 2'b01;
            end
            AUIPC: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            TRAP: begin
                bus.illegal_instr = 1'b1;
                bus.retire        = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format is decoded from op alone so it is valid in every state.
    always_comb begin
        unique case (bus.op)
            OP_STORE:         bus.ImmSrc = 3'b001;
            OP_BRANCH:        bus.ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b011;
            OP_JAL:           bus.ImmSrc = 3'b100;
            default:          bus.ImmSrc = 3'b000;
        endcase
    end
endmodule
